phy_rx_link_ctrl: RTL and testbench

Link-training controller for the two-lane PHY receive path. Watches both lanes' sync flags (`active_serial_paralelo_*`) and the recovered byte streams. Once both lanes show a stable run of 0xBC COM symbols, it measures inter-lane skew, programs the downstream deskew buffer, and enables byte-to-word reassembly. It supervises the link in RUN and retrains on loss of sync, with a saturating retry count.

---
 rtl/phy_rx_link_ctrl_pkg.sv | 20 ++
 rtl/phy_rx_link_ctrl_if.sv | 30 +++
 rtl/phy_rx_link_ctrl_lane_ts_counter.sv | 48 ++++
 rtl/phy_rx_link_ctrl.sv | 153 +++++++++++++++
 tb/tb_phy_rx_link_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/phy_rx_link_ctrl_pkg.sv
// Shared definitions for the two-lane PHY receive link controller:
// state encodings, the COM symbol and the retry counter width.
package phy_rx_link_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_ACTIVE = 3'd0,
    ST_TRAIN       = 3'd1,
    ST_DESKEW      = 3'd2,
    ST_RUN         = 3'd3,
    ST_ERROR       = 3'd4
  } link_state_e;

  localparam logic [7:0] COM_SYMBOL = 8'hBC;
  localparam int unsigned RETRY_W = 4;

  function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/phy_rx_link_ctrl_if.sv
// Lane-side bundle: per-lane sync flags, recovered bytes and byte qualifiers.
// The PHY front end drives it (master); the link controller observes it (slave).
interface phy_rx_link_ctrl_if;

  logic       active_serial_paralelo_0;
  logic       active_serial_paralelo_1;
  logic [7:0] data_lane_0;
  logic [7:0] data_lane_1;
  logic       valid_lane_0;
  logic       valid_lane_1;

  modport master (
    output active_serial_paralelo_0,
    output active_serial_paralelo_1,
    output data_lane_0,
    output data_lane_1,
    output valid_lane_0,
    output valid_lane_1
  );

  modport slave (
    input active_serial_paralelo_0,
    input active_serial_paralelo_1,
    input data_lane_0,
    input data_lane_1,
    input valid_lane_0,
    input valid_lane_1
  );

endinterface

// File: rtl/phy_rx_link_ctrl_lane_ts_counter.sv
// Per-lane COM run counter (saturate / clear on data / hold when invalid)
// plus the sticky "first data byte seen" flag used for skew measurement.
module lane_ts_counter
  import phy_rx_link_ctrl_pkg::*;
#(
  parameter int unsigned TS_COUNT = 4
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_train_en,
  input  logic       i_seen_en,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ts_done,
  output logic       o_seen
);

  localparam int unsigned CNT_W = $clog2(TS_COUNT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_seen;
  logic             w_is_com;

  assign w_is_com = (i_data == COM_SYMBOL);

  always_ff @(posedge clk_4f) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_train_en && i_valid) begin
      if (!w_is_com)
        r_cnt <= '0;
      else if (r_cnt != CNT_W'(TS_COUNT))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset || i_clear)
      r_seen <= 1'b0;
    else if (i_seen_en && i_valid && !w_is_com)
      r_seen <= 1'b1;
  end

  assign o_ts_done = (r_cnt == CNT_W'(TS_COUNT));
  assign o_seen    = r_seen;

endmodule

// File: rtl/phy_rx_link_ctrl.sv
// Two-lane link-training controller: waits for lane sync, trains on COM runs,
// measures inter-lane skew, then supervises the link and retrains on errors.
module phy_rx_link_ctrl
  import phy_rx_link_ctrl_pkg::*;
#(
  parameter int unsigned TS_COUNT      = 4,
  parameter int unsigned MAX_SKEW      = 3,
  parameter int unsigned TRAIN_TIMEOUT = 255,
  parameter int unsigned ERR_HOLD      = 16,
  parameter int unsigned SKW_W         = 2
) (
  input  logic                clk_4f,
  input  logic                reset,
  phy_rx_link_ctrl_if.slave   lanes,
  output logic                link_up,
  output logic                rx_enable,
  output logic                deskew_lane,
  output logic [SKW_W-1:0]    deskew_amt,
  output logic                link_error,
  output logic [RETRY_W-1:0]  retry_count,
  output logic [2:0]          state_out
);

  localparam int unsigned TMO_W  = $clog2(TRAIN_TIMEOUT + 1);
  localparam int unsigned HOLD_W = $clog2(ERR_HOLD + 1);

  link_state_e        r_state, w_state_nxt;
  logic [TMO_W-1:0]   r_tmo;
  logic [HOLD_W-1:0]  r_hold;
  logic [SKW_W-1:0]   r_skew;
  logic               r_first;
  logic               r_link_up;
  logic               r_deskew_lane;
  logic [SKW_W-1:0]   r_deskew_amt;
  logic               r_link_error;
  logic [RETRY_W-1:0] r_retry;

  logic w_sync, w_in_wait, w_in_train, w_in_deskew;
  logic w_done0, w_done1, w_seen0, w_seen1, w_one_seen;
  logic w_tmo_hit, w_skew_ovf, w_hold_done, w_err_entry;

  assign w_sync      = lanes.active_serial_paralelo_0 && lanes.active_serial_paralelo_1;
  assign w_in_wait   = (r_state == ST_WAIT_ACTIVE);
  assign w_in_train  = (r_state == ST_TRAIN);
  assign w_in_deskew = (r_state == ST_DESKEW);

  lane_ts_counter #(.TS_COUNT(TS_COUNT)) u_lane0 (
    .clk_4f     (clk_4f),
    .reset      (reset),
    .i_clear    (w_in_wait),
    .i_train_en (w_in_train),
    .i_seen_en  (w_in_deskew),
    .i_valid    (lanes.valid_lane_0),
    .i_data     (lanes.data_lane_0),
    .o_ts_done  (w_done0),
    .o_seen     (w_seen0)
  );

  lane_ts_counter #(.TS_COUNT(TS_COUNT)) u_lane1 (
    .clk_4f     (clk_4f),
    .reset      (reset),
    .i_clear    (w_in_wait),
    .i_train_en (w_in_train),
    .i_seen_en  (w_in_deskew),
    .i_valid    (lanes.valid_lane_1),
    .i_data     (lanes.data_lane_1),
    .o_ts_done  (w_done1),
    .o_seen     (w_seen1)
  );

  assign w_one_seen  = w_seen0 ^ w_seen1;
  assign w_tmo_hit   = (r_tmo == TMO_W'(TRAIN_TIMEOUT - 1));
  assign w_skew_ovf  = w_one_seen && (r_skew == SKW_W'(MAX_SKEW));
  assign w_hold_done = (r_hold == HOLD_W'(ERR_HOLD - 1));

  // Error causes are all funnelled into one ERROR transition, so coincident
  // skew overflow and timeout still yield a single entry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT_ACTIVE: if (w_sync) w_state_nxt = ST_TRAIN;
      ST_TRAIN: begin
        if (!w_sync || w_tmo_hit)  w_state_nxt = ST_ERROR;
        else if (w_done0 && w_done1) w_state_nxt = ST_DESKEW;
      end
      ST_DESKEW: begin
        if (!w_sync || w_tmo_hit || w_skew_ovf) w_state_nxt = ST_ERROR;
        else if (w_seen0 && w_seen1)            w_state_nxt = ST_RUN;
      end
      ST_RUN:   if (!w_sync) w_state_nxt = ST_ERROR;
      ST_ERROR: if (w_hold_done) w_state_nxt = ST_WAIT_ACTIVE;
      default:  w_state_nxt = ST_WAIT_ACTIVE;
    endcase
  end

  assign w_err_entry = (w_state_nxt == ST_ERROR) && (r_state != ST_ERROR);

  always_ff @(posedge clk_4f) begin
    if (reset) r_state <= ST_WAIT_ACTIVE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_4f) begin
    if (reset || w_in_wait)        r_tmo <= '0;
    else if (w_in_train || w_in_deskew) r_tmo <= r_tmo + 1'b1;
  end

  always_ff @(posedge clk_4f) begin
    if (reset || r_state != ST_ERROR) r_hold <= '0;
    else if (!w_hold_done)            r_hold <= r_hold + 1'b1;
  end

  // r_first tracks which lane was seen alone; it stays 0 when both arrive together.
  always_ff @(posedge clk_4f) begin
    if (reset || w_in_wait) begin
      r_skew  <= '0;
      r_first <= 1'b0;
    end else if (w_in_deskew && w_one_seen) begin
      r_first <= w_seen1;
      if (!w_skew_ovf) r_skew <= r_skew + 1'b1;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      r_link_up     <= 1'b0;
      r_deskew_lane <= 1'b0;
      r_deskew_amt  <= '0;
      r_link_error  <= 1'b0;
      r_retry       <= '0;
    end else begin
      r_link_up    <= (w_state_nxt == ST_RUN);
      r_link_error <= w_err_entry;
      if (w_err_entry) r_retry <= retry_sat_inc(r_retry);
      if (w_in_deskew && w_state_nxt == ST_RUN) begin
        r_deskew_lane <= r_first;
        r_deskew_amt  <= r_skew;
      end else if (w_state_nxt != ST_RUN) begin
        r_deskew_lane <= 1'b0;
        r_deskew_amt  <= '0;
      end
    end
  end

  assign link_up     = r_link_up;
  assign rx_enable   = r_link_up;
  assign deskew_lane = r_deskew_lane;
  assign deskew_amt  = r_deskew_amt;
  assign link_error  = r_link_error;
  assign retry_count = r_retry;
  assign state_out   = r_state;

endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// Directed bench for phy_rx_link_ctrl: training, deskew, errors, timeout,
// retry saturation and mid-operation reset, with hand-computed expectations.
module tb_phy_rx_link_ctrl;

  localparam logic [7:0] BC = 8'hBC;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic       link_up, rx_enable, deskew_lane, link_error;
  logic [1:0] deskew_amt;
  logic [3:0] retry_count;
  logic [2:0] state_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_4f = ~clk_4f;

  phy_rx_link_ctrl_if lanes();

  phy_rx_link_ctrl #(
    .TS_COUNT(4), .MAX_SKEW(3), .TRAIN_TIMEOUT(255), .ERR_HOLD(16), .SKW_W(2)
  ) dut (
    .clk_4f      (clk_4f),
    .reset       (reset),
    .lanes       (lanes.slave),
    .link_up     (link_up),
    .rx_enable   (rx_enable),
    .deskew_lane (deskew_lane),
    .deskew_amt  (deskew_amt),
    .link_error  (link_error),
    .retry_count (retry_count),
    .state_out   (state_out)
  );

  task automatic step(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk_4f);
      #1;
    end
  endtask

  task automatic set_sync(input logic s0, input logic s1);
    lanes.active_serial_paralelo_0 = s0;
    lanes.active_serial_paralelo_1 = s1;
  endtask

  task automatic set_lanes(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
    lanes.valid_lane_0 = v0;
    lanes.data_lane_0  = d0;
    lanes.valid_lane_1 = v1;
    lanes.data_lane_1  = d1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int lu, input int dl,
                         input int da, input int le, input int rc);
    chk({tag, ".state"},       32'(state_out),   32'(st));
    chk({tag, ".link_up"},     32'(link_up),     32'(lu));
    chk({tag, ".rx_enable"},   32'(rx_enable),   32'(lu));
    chk({tag, ".deskew_lane"}, 32'(deskew_lane), 32'(dl));
    chk({tag, ".deskew_amt"},  32'(deskew_amt),  32'(da));
    chk({tag, ".link_error"},  32'(link_error),  32'(le));
    chk({tag, ".retry_count"}, 32'(retry_count), 32'(rc));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_sync(1'b0, 1'b0);
    set_lanes(1'b0, 8'h00, 1'b0, 8'h00);
    step(2);
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  // Sync, then four COM bytes on both lanes; leaves the FSM in DESKEW.
  task automatic train_both(input string tag);
    set_sync(1'b1, 1'b1);
    step(1);
    chk({tag, ".train"}, 32'(state_out), 32'd1);
    set_lanes(1'b1, BC, 1'b1, BC);
    step(4);
    chk({tag, ".still_train"}, 32'(state_out), 32'd1);
    set_lanes(1'b0, 8'h00, 1'b0, 8'h00);
    step(1);
    chk({tag, ".deskew"}, 32'(state_out), 32'd2);
  endtask

  logic [7:0] seq0 [7] = '{BC, BC, 8'h55, BC, BC, BC, BC};
  int exp_retry;

  initial begin
    // Aligned lanes: zero skew.
    do_reset();
    train_both("t1");
    set_lanes(1'b1, 8'h11, 1'b1, 8'h11);
    step(1);
    chk("t1.seen_same", 32'(state_out), 32'd2);
    set_lanes(1'b0, 8'h00, 1'b0, 8'h00);
    step(1);
    chk_all("t1.run", 3, 1, 0, 0, 0, 0);

    // Lane 1 two cycles late.
    do_reset();
    train_both("t2");
    set_lanes(1'b1, 8'h22, 1'b0, 8'h00);
    step(1);
    set_lanes(1'b0, 8'h00, 1'b0, 8'h00);
    step(1);
    set_lanes(1'b0, 8'h00, 1'b1, 8'h33);
    step(1);
    chk("t2.pre_run", 32'(state_out), 32'd2);
    set_lanes(1'b1, BC, 1'b1, BC);
    step(1);
    chk_all("t2.run", 3, 1, 0, 2, 0, 0);
    set_lanes(1'b1, 8'h44, 1'b1, 8'h45);
    step(3);
    chk_all("t2.stable", 3, 1, 0, 2, 0, 0);

    // Loss of lane 1 sync in RUN, then the full ERROR hold.
    set_sync(1'b1, 1'b0);
    step(1);
    chk_all("t5.err_entry", 4, 0, 0, 0, 1, 1);
    step(1);
    chk_all("t5.err_hold", 4, 0, 0, 0, 0, 1);
    step(14);
    chk("t5.err_last", 32'(state_out), 32'd4);
    step(1);
    chk("t5.wait", 32'(state_out), 32'd0);

    // Repeated forced errors: retry_count saturates at 15.
    exp_retry = 1;
    for (int i = 0; i < 16; i++) begin
      set_sync(1'b1, 1'b1);
      step(1);
      set_sync(1'b0, 1'b0);
      step(1);
      exp_retry = (exp_retry < 15) ? exp_retry + 1 : 15;
      chk("t5.retry_sat", 32'(retry_count), 32'(exp_retry));
      step(16);
    end
    chk_all("t5.sat_final", 0, 0, 0, 0, 0, 15);

    // Lane 1 early by three cycles: largest tolerated skew.
    do_reset();
    train_both("t7");
    set_lanes(1'b0, 8'h00, 1'b1, 8'h66);
    step(3);
    set_lanes(1'b1, 8'h77, 1'b0, 8'h00);
    step(1);
    chk("t7.pre_run", 32'(state_out), 32'd2);
    set_lanes(1'b0, 8'h00, 1'b0, 8'h00);
    step(1);
    chk_all("t7.run", 3, 1, 1, 3, 0, 0);

    // Lane 0 four cycles early: skew overflow.
    do_reset();
    train_both("t3");
    set_lanes(1'b1, 8'h12, 1'b0, 8'h00);
    step(1);
    set_lanes(1'b0, 8'h00, 1'b0, 8'h00);
    step(3);
    chk("t3.pre_err", 32'(state_out), 32'd2);
    set_lanes(1'b0, 8'h00, 1'b1, 8'h34);
    step(1);
    chk_all("t3.err", 4, 0, 0, 0, 1, 1);
    set_lanes(1'b0, 8'h00, 1'b0, 8'h00);
    step(15);
    chk("t3.err_last", 32'(state_out), 32'd4);
    step(1);
    chk("t3.wait", 32'(state_out), 32'd0);
    set_sync(1'b0, 1'b0);

    // Non-COM byte on lane 0 restarts its run.
    do_reset();
    set_sync(1'b1, 1'b1);
    step(1);
    for (int i = 0; i < 7; i++) begin
      set_lanes(1'b1, seq0[i], 1'b1, BC);
      step(1);
      if (i == 5) chk("t4.no_early_deskew", 32'(state_out), 32'd1);
    end
    chk("t4.last_bc_train", 32'(state_out), 32'd1);
    set_lanes(1'b0, 8'h00, 1'b0, 8'h00);
    step(1);
    chk("t4.deskew", 32'(state_out), 32'd2);

    // Timeout with no COM bytes, then reset during ERROR.
    do_reset();
    set_sync(1'b1, 1'b1);
    step(1);
    chk("t6.train", 32'(state_out), 32'd1);
    step(254);
    chk("t6.pre_timeout", 32'(state_out), 32'd1);
    step(1);
    chk_all("t6.timeout", 4, 0, 0, 0, 1, 1);
    set_sync(1'b0, 1'b1);
    step(3);
    chk("t6.ignores_sync", 32'(state_out), 32'd4);
    reset = 1'b1;
    step(1);
    chk_all("t6.reset_in_err", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
